// File: rtl/serial_operand_feeder.sv
// Serialises an operand pair MSB-first into a bit-serial comparator,
// clearing it first and holding its result window afterwards.
module serial_operand_feeder #(
  parameter int WIDTH       = 8,
  parameter int DONE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ready,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             cmp_rst,
  output logic             op,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] BIT_INIT = CW'(WIDTH - 1);
  localparam logic [3:0] HOLD_INIT = 4'(DONE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_bit_cnt;
  logic [3:0]       r_hold_cnt;

  logic w_bit_last;
  logic w_hold_last;

  assign w_bit_last  = (r_bit_cnt == '0);
  assign w_hold_last = (r_hold_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs depend on registered state only, never on inputs.
  always_comb begin
    w_next    = r_state;
    ready     = 1'b0;
    op        = 1'b1;
    cmp_rst   = 1'b0;
    bit_valid = 1'b0;
    done      = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cmp_rst = 1'b1;
        w_next  = S_SHIFT;
      end
      S_SHIFT: begin
        bit_valid = 1'b1;
        a_bit     = r_sa[WIDTH-1];
        b_bit     = r_sb[WIDTH-1];
        if (w_bit_last) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        op   = 1'b0;
        done = 1'b1;
        if (w_hold_last) begin
          w_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa       <= '0;
      r_sb       <= '0;
      r_bit_cnt  <= '0;
      r_hold_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa <= in_a;
            r_sb <= in_b;
          end
        end
        S_CLEAR: begin
          r_bit_cnt <= BIT_INIT;
        end
        S_SHIFT: begin
          r_sa <= r_sa << 1;
          r_sb <= r_sb << 1;
          // Counters saturate at zero rather than wrap.
          if (!w_bit_last) begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end else begin
            r_hold_cnt <= HOLD_INIT;
          end
        end
        S_HOLD: begin
          if (!w_hold_last) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule
